// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: register-file write-back arbiter with an in-order load queue and busy-bit scoreboard
module reg_wb_ctrl #(
  parameter int W = 8,
  parameter int D = 4,
  parameter int LQ_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_alu_valid,
  input  logic [D-1:0]                i_alu_addr,
  input  logic [W-1:0]                i_alu_data,
  output logic                        o_alu_ready,
  input  logic                        i_ld_issue,
  input  logic [D-1:0]                i_ld_addr,
  output logic                        o_ld_issue_ready,
  input  logic                        i_ld_rvalid,
  input  logic [W-1:0]                i_ld_rdata,
  input  logic [D-1:0]                i_chk_addr_a,
  input  logic [D-1:0]                i_chk_addr_b,
  output logic                        o_hazard,
  output logic                        o_rf_we,
  output logic [D-1:0]                o_rf_waddr,
  output logic [W-1:0]                o_rf_wdata,
  output logic [$clog2(LQ_DEPTH):0]   o_lq_count,
  output logic                        o_err
);
  localparam int PW = $clog2(LQ_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(LQ_DEPTH);
  logic [D-1:0]      r_lq [LQ_DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [PW:0]       r_cnt;
  logic [2**D-1:0]   r_busy;
  logic              r_clr;
  logic [D-1:0]      r_clr_addr;
  logic              r_we;
  logic [D-1:0]      r_waddr;
  logic [W-1:0]      r_wdata;
  logic              r_err;
  logic              w_ret, w_issue, w_alu;
  logic [D-1:0]      w_head;
  logic [2**D-1:0]   w_busy_nxt;
  assign w_head           = r_lq[r_rp];
  assign w_ret            = i_ld_rvalid && r_cnt != '0;
  assign o_ld_issue_ready = r_cnt != FULL && !r_busy[i_ld_addr];
  assign o_alu_ready      = !w_ret && !r_busy[i_alu_addr];
  assign w_issue          = i_ld_issue && o_ld_issue_ready;
  assign w_alu            = i_alu_valid && o_alu_ready;
  assign o_hazard         = r_busy[i_chk_addr_a] | r_busy[i_chk_addr_b];
  assign o_rf_we          = r_we;
  assign o_rf_waddr       = r_waddr;
  assign o_rf_wdata       = r_wdata;
  assign o_lq_count       = r_cnt;
  assign o_err            = r_err;
  // busy clears one cycle after the return, on the edge the register file captures the data
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_clr) w_busy_nxt[r_clr_addr] = 1'b0;
    if (w_issue) w_busy_nxt[i_ld_addr] = 1'b1;
  end
  always_ff @(posedge i_clk)
    if (w_issue) r_lq[r_wp] <= i_ld_addr;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_busy     <= '0;
      r_clr      <= 1'b0;
      r_clr_addr <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wp       <= r_wp + PW'(w_issue);
      r_rp       <= r_rp + PW'(w_ret);
      r_cnt      <= r_cnt + (PW+1)'(w_issue) - (PW+1)'(w_ret);
      r_busy     <= w_busy_nxt;
      r_clr      <= w_ret;
      r_clr_addr <= w_head;
      r_we       <= w_ret || w_alu;
      if (w_ret) begin
        r_waddr <= w_head;
        r_wdata <= i_ld_rdata;
      end else if (w_alu) begin
        r_waddr <= i_alu_addr;
        r_wdata <= i_alu_data;
      end
      if (i_ld_rvalid && r_cnt == '0) r_err <= 1'b1;
    end
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// tb_reg_wb_ctrl: directed stimulus with a write-back scoreboard checked by a separate monitor
module tb_reg_wb_ctrl;
  logic       clk = 0, rst = 1;
  logic       alu_valid = 0, ld_issue = 0, ld_rvalid = 0;
  logic [3:0] alu_addr = 0, ld_addr = 0, chk_a = 0, chk_b = 0;
  logic [7:0] alu_data = 0, ld_rdata = 0;
  logic       alu_ready, ld_issue_ready, hazard, rf_we, err;
  logic [3:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [2:0] lq_count;
  logic [11:0] sb[$];
  int tests = 0, fails = 0;

  reg_wb_ctrl dut (
    .i_clk(clk), .i_rst(rst),
    .i_alu_valid(alu_valid), .i_alu_addr(alu_addr), .i_alu_data(alu_data), .o_alu_ready(alu_ready),
    .i_ld_issue(ld_issue), .i_ld_addr(ld_addr), .o_ld_issue_ready(ld_issue_ready),
    .i_ld_rvalid(ld_rvalid), .i_ld_rdata(ld_rdata),
    .i_chk_addr_a(chk_a), .i_chk_addr_b(chk_b), .o_hazard(hazard),
    .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
    .o_lq_count(lq_count), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] d);
    sb.push_back({a, d});
  endtask

  always @(negedge clk)
    if (!rst && rf_we) begin
      if (sb.size() == 0) chk("unexpected_write", {20'h0, rf_waddr, rf_wdata}, 32'hFFFF_FFFF);
      else begin
        logic [11:0] e;
        e = sb.pop_front();
        chk("wb_addr", 32'(rf_waddr), 32'(e[11:8]));
        chk("wb_data", 32'(rf_wdata), 32'(e[7:0]));
      end
    end

  initial begin
    #12;
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_waddr", 32'(rf_waddr), 0);
    chk("rst_wdata", 32'(rf_wdata), 0);
    chk("rst_lq", 32'(lq_count), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_hazard", 32'(hazard), 0);
    rst = 0;
    tick;
    // ALU write
    alu_valid = 1; alu_addr = 3; alu_data = 8'h5A; #1;
    chk("alu_ready_idle", 32'(alu_ready), 1);
    push(3, 8'h5A);
    tick; alu_valid = 0;
    chk("alu_we", 32'(rf_we), 1);
    tick;
    chk("alu_we_drop", 32'(rf_we), 0);
    // single load
    ld_issue = 1; ld_addr = 5; #1;
    chk("issue_ready_r5", 32'(ld_issue_ready), 1);
    tick; ld_issue = 0; chk_a = 5; #1;
    chk("hazard_r5", 32'(hazard), 1);
    chk("lq_one", 32'(lq_count), 1);
    ld_rvalid = 1; ld_rdata = 8'hC3; push(5, 8'hC3);
    tick; ld_rvalid = 0; #1;
    chk("hazard_during_wb", 32'(hazard), 1);
    tick;
    chk("hazard_cleared", 32'(hazard), 0);
    chk("lq_zero", 32'(lq_count), 0);
    // return beats ALU
    ld_issue = 1; ld_addr = 2;
    tick; ld_issue = 0;
    ld_rvalid = 1; ld_rdata = 8'h11; alu_valid = 1; alu_addr = 7; alu_data = 8'h77; #1;
    chk("alu_blocked_by_ret", 32'(alu_ready), 0);
    push(2, 8'h11);
    tick; ld_rvalid = 0; #1;
    chk("alu_retry_ready", 32'(alu_ready), 1);
    push(7, 8'h77);
    tick; alu_valid = 0;
    tick;
    // fill queue, simultaneous issue/return, wrap
    ld_issue = 1;
    for (int i = 1; i <= 4; i++) begin
      ld_addr = 4'(i);
      tick;
    end
    ld_addr = 6; #1;
    chk("lq_full", 32'(lq_count), 4);
    chk("issue_ready_full", 32'(ld_issue_ready), 0);
    ld_rvalid = 1; ld_rdata = 8'hA1; #1;
    chk("issue_refused_on_ret", 32'(ld_issue_ready), 0);
    push(1, 8'hA1);
    tick; ld_rvalid = 0; #1;
    chk("lq_after_ret", 32'(lq_count), 3);
    chk("issue_ready_r6", 32'(ld_issue_ready), 1);
    tick; ld_issue = 0;
    chk("lq_refill", 32'(lq_count), 4);
    ld_rvalid = 1;
    ld_rdata = 8'hA2; push(2, 8'hA2); tick;
    ld_rdata = 8'hA3; push(3, 8'hA3); tick;
    ld_rdata = 8'hA4; push(4, 8'hA4); tick;
    ld_rdata = 8'hA6; push(6, 8'hA6); tick;
    ld_rvalid = 0;
    tick; tick;
    chk("lq_drained", 32'(lq_count), 0);
    // WAW stall
    ld_issue = 1; ld_addr = 9;
    tick; ld_issue = 0;
    chk_a = 0; chk_b = 9; alu_valid = 1; alu_addr = 9; alu_data = 8'h99; #1;
    chk("hazard_b_r9", 32'(hazard), 1);
    chk("alu_waw_stall", 32'(alu_ready), 0);
    tick;
    ld_rvalid = 1; ld_rdata = 8'h90; push(9, 8'h90); #1;
    chk("alu_waw_ret", 32'(alu_ready), 0);
    tick; ld_rvalid = 0; #1;
    chk("alu_waw_wbcycle", 32'(alu_ready), 0);
    tick;
    chk("alu_waw_release", 32'(alu_ready), 1);
    push(9, 8'h99);
    tick; alu_valid = 0;
    tick;
    chk("r9_final_addr", 32'(rf_waddr), 9);
    chk("r9_final_data", 32'(rf_wdata), 32'h99);
    // underflow
    ld_rvalid = 1; ld_rdata = 8'hEE;
    tick; ld_rvalid = 0;
    chk("underflow_no_we", 32'(rf_we), 0);
    chk("err_set", 32'(err), 1);
    tick;
    chk("err_sticky", 32'(err), 1);
    // async reset mid-stream
    ld_issue = 1;
    ld_addr = 1; tick;
    ld_addr = 2; tick;
    ld_addr = 3; alu_valid = 1; alu_addr = 10; alu_data = 8'h55; push(10, 8'h55);
    tick; ld_issue = 0; alu_valid = 0; chk_a = 2;
    chk("lq_three", 32'(lq_count), 3);
    @(negedge clk); #1;
    chk("hazard_pre_rst", 32'(hazard), 1);
    chk("we_pre_rst", 32'(rf_we), 1);
    rst = 1; #1;
    chk("async_lq", 32'(lq_count), 0);
    chk("async_hazard", 32'(hazard), 0);
    chk("async_err", 32'(err), 0);
    chk("async_we", 32'(rf_we), 0);
    tick;
    rst = 0;
    tick; tick;
    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
